// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating signed dot-product accumulator with a valid/ready result port
module mac_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              res_ready,
  output logic              busy,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res,
  output logic              sat_flag,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc, sat_sum;
  logic [ACC_W:0] sum;
  logic [15:0] remaining;
  logic ovf;
  // one guard bit: overflow shows as disagreement between the top two sum bits
  always_comb begin
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    ovf = sum[ACC_W] ^ sum[ACC_W-1];
    sat_sum = !ovf ? sum[ACC_W-1:0] :
              sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? (len != 16'd0 ? ACC : DONE) : IDLE;
      ACC: state_n = (prod_valid && remaining == 16'd1) ? DONE : ACC;
      DONE: state_n = res_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      remaining <= '0;
      res <= '0;
      sat_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (state != ACC && prod_valid && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (state == IDLE && start) begin
        acc <= '0;
        sat_flag <= 1'b0;
        remaining <= len;
        if (len == 16'd0) res <= '0;
      end
      if (state == ACC && prod_valid) begin
        acc <= sat_sum;
        remaining <= remaining - 16'd1;
        if (ovf) sat_flag <= 1'b1;
        if (remaining == 16'd1) res <= sat_sum;
      end
    end
  end
  assign busy = state != IDLE;
  assign res_valid = state == DONE;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed checks of accumulation, saturation, handshake, reset and drop counting
module tb_mac_accumulator;
  logic clk = 1'b0, rst, start, prod_valid, res_ready, busy, res_valid, sat_flag;
  logic [15:0] len;
  logic [31:0] prod;
  logic [35:0] res;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_err = 0;

  mac_accumulator #(.PROD_W(32), .ACC_W(36)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid), .prod(prod),
    .res_ready(res_ready), .busy(busy), .res_valid(res_valid), .res(res),
    .sat_flag(sat_flag), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; res_ready = 1'b1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    // four back-to-back products
    start = 1'b1; len = 16'd4; step(); start = 1'b0;
    chk("dp_busy", busy, 1);
    prod_valid = 1'b1;
    prod = 32'd100; step();
    prod = -32'sd50; step();
    prod = 32'd7; step();
    chk("dp_not_yet", res_valid, 0);
    prod = 32'd3; step(); prod_valid = 1'b0;
    chk("dp_valid", res_valid, 1);
    chk("dp_res", res, 60);
    chk("dp_sat", sat_flag, 0);
    step();
    chk("dp_idle_valid", res_valid, 0);
    chk("dp_idle_busy", busy, 0);
    chk("dp_res_kept", res, 60);
    // products separated by bubbles, result held while not ready
    res_ready = 1'b0;
    start = 1'b1; len = 16'd3; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'd5; step(); prod_valid = 1'b0; step(); step();
    prod_valid = 1'b1; prod = 32'd6; step(); prod_valid = 1'b0; step(); step();
    chk("gap_not_yet", res_valid, 0);
    prod_valid = 1'b1; prod = 32'd7; step(); prod_valid = 1'b0;
    step(); step();
    chk("gap_valid", res_valid, 1);
    chk("gap_res", res, 18);
    chk("gap_drop", drop_cnt, 0);
    res_ready = 1'b1; step();
    chk("gap_idle", busy, 0);
    // positive saturation
    start = 1'b1; len = 16'd17; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'h7fffffff;
    repeat (17) step();
    prod_valid = 1'b0;
    chk("psat_res", res, 36'h7ffffffff);
    chk("psat_flag", sat_flag, 1);
    step();
    // exact negative limit, no saturation
    start = 1'b1; len = 16'd16; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'h80000000;
    repeat (16) step();
    prod_valid = 1'b0;
    chk("nlim_res", res, 36'h800000000);
    chk("nlim_flag", sat_flag, 0);
    step();
    // negative saturation
    start = 1'b1; len = 16'd17; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'h80000000;
    repeat (17) step();
    prod_valid = 1'b0;
    chk("nsat_res", res, 36'h800000000);
    chk("nsat_flag", sat_flag, 1);
    step();
    // zero-length job, held in DONE while start is ignored
    res_ready = 1'b0;
    start = 1'b1; len = 16'd0; step(); start = 1'b0;
    chk("zl_valid", res_valid, 1);
    chk("zl_res", res, 0);
    chk("zl_sat", sat_flag, 0);
    step(); step();
    start = 1'b1; len = 16'd4; step(); start = 1'b0;
    step(); step();
    chk("zl_hold_valid", res_valid, 1);
    chk("zl_hold_res", res, 0);
    start = 1'b1; len = 16'd4; res_ready = 1'b1; step(); start = 1'b0;
    chk("zl_hs_busy", busy, 0);
    chk("zl_hs_valid", res_valid, 0);
    // reset mid-accumulation, with start asserted alongside
    start = 1'b1; len = 16'd4; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'd10; step(); step(); prod_valid = 1'b0;
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_valid", res_valid, 0);
    repeat (3) begin
      prod_valid = 1'b1; step(); prod_valid = 1'b0; step();
    end
    chk("mr_drop", drop_cnt, 3);
    chk("mr_no_valid", res_valid, 0);
    // drop counter saturation
    prod_valid = 1'b1;
    repeat (300) step();
    chk("drop_sat", drop_cnt, 255);
    repeat (5) step();
    prod_valid = 1'b0;
    chk("drop_stay", drop_cnt, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
